// File: rtl/mem_if.sv
// Bridges the CPU's held rd/wr handshake onto a single-cycle synchronous RAM port,
// inserting programmable wait states and tracking the RAM's fixed read latency.
module mem_if #(
    parameter int READ_LATENCY = 2,
    parameter int WAIT_STATES  = 0,
    parameter int DATA_W       = 16,
    parameter int RAM_AW       = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_addr,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_waitrequest,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rddatavalid,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_wren,
    output logic [DATA_W-1:0] o_ram_wrdata,
    input  logic [DATA_W-1:0] i_ram_q,
    output logic              o_protocol_err
);

    localparam int                LCNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [2:0]        WCNT_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam logic [LCNT_W-1:0] LCNT_LOAD = LCNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_READ
    } state_t;

    state_t              r_state;
    logic [2:0]          r_wcnt;
    logic [LCNT_W-1:0]   r_lcnt;
    logic [RAM_AW-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wrdata;
    logic [DATA_W-1:0]   r_rddata;
    logic                r_rddatavalid;
    logic                r_protocol_err;

    logic                w_req;
    logic                w_accept;
    logic                w_ram_go;
    logic                w_rd_only;

    assign w_req     = i_rd | i_wr;
    assign w_rd_only = i_rd & ~i_wr;
    assign w_accept  = w_req & (((r_state == S_IDLE) & (WAIT_STATES == 0)) |
                                ((r_state == S_STALL) & (r_wcnt == 3'd0)));

    assign o_waitrequest = w_req & ~w_accept;

    // The accept-cycle bypass is masked by rst so the RAM port reads all-zero while reset is held.
    assign w_ram_go     = w_accept & ~rst;
    assign o_ram_wren   = w_ram_go & i_wr;
    assign o_ram_addr   = w_ram_go ? i_addr[RAM_AW-1:0] : r_ram_addr;
    assign o_ram_wrdata = w_ram_go ? i_wrdata : r_ram_wrdata;

    assign o_rddata       = r_rddata;
    assign o_rddatavalid  = r_rddatavalid;
    assign o_protocol_err = r_protocol_err;

    generate
        if (RAM_AW < 16) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^i_addr[15:RAM_AW];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wcnt         <= 3'd0;
            r_lcnt         <= '0;
            r_ram_addr     <= '0;
            r_ram_wrdata   <= '0;
            r_rddata       <= '0;
            r_rddatavalid  <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_rddatavalid <= 1'b0;

            if (w_accept) begin
                r_ram_addr   <= i_addr[RAM_AW-1:0];
                r_ram_wrdata <= i_wrdata;
                if (i_rd & i_wr) begin
                    r_protocol_err <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (WAIT_STATES > 0) begin
                            r_wcnt  <= WCNT_LOAD;
                            r_state <= S_STALL;
                        end else if (w_rd_only) begin
                            r_lcnt  <= LCNT_LOAD;
                            r_state <= S_READ;
                        end
                    end
                end

                S_STALL: begin
                    // A request withdrawn before acceptance is a CPU protocol violation.
                    if (!w_req) begin
                        r_protocol_err <= 1'b1;
                        r_wcnt         <= 3'd0;
                        r_state        <= S_IDLE;
                    end else if (r_wcnt == 3'd0) begin
                        if (w_rd_only) begin
                            r_lcnt  <= LCNT_LOAD;
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end
                end

                S_READ: begin
                    if (r_lcnt == '0) begin
                        r_rddata      <= i_ram_q;
                        r_rddatavalid <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_lcnt <= r_lcnt - LCNT_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_if.sv
// Randomised scoreboard bench for mem_if: three instances with different latency and
// wait-state settings, each backed by a small synchronous RAM with matching read latency.
`timescale 1ns/1ps
module tb_mem_if;

   localparam int NI = 3;
   localparam int DW = 16;
   localparam int AW = 12;

   function automatic int latOf(input int k);
      case (k)
         0:       return 2;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int wsOf(input int k);
      case (k)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic logic [DW-1:0] initVal(input int k, input int a);
      return DW'((a * 40503) ^ (k * 4369) ^ 16'h5A5A);
   endfunction

   logic clk = 1'b0;
   logic rst;
   logic ramClear;
   int   cyc;

   logic [15:0]   addr      [NI];
   logic          rd        [NI];
   logic          wr        [NI];
   logic [DW-1:0] wrData    [NI];
   logic          waitReq   [NI];
   logic [DW-1:0] rdData    [NI];
   logic          rdValid   [NI];
   logic [AW-1:0] ramAddr   [NI];
   logic          ramWren   [NI];
   logic [DW-1:0] ramWrdata [NI];
   logic          protErr   [NI];

   logic [DW-1:0] ramMem  [NI][4096];
   logic [DW-1:0] ramPipe [NI][8];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LATG = latOf(g);
      mem_if #(
         .READ_LATENCY(LATG),
         .WAIT_STATES (wsOf(g)),
         .DATA_W      (DW),
         .RAM_AW      (AW)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .i_addr        (addr[g]),
         .i_rd          (rd[g]),
         .i_wr          (wr[g]),
         .i_wrdata      (wrData[g]),
         .o_waitrequest (waitReq[g]),
         .o_rddata      (rdData[g]),
         .o_rddatavalid (rdValid[g]),
         .o_ram_addr    (ramAddr[g]),
         .o_ram_wren    (ramWren[g]),
         .o_ram_wrdata  (ramWrdata[g]),
         .i_ram_q       (ramPipe[g][LATG-1]),
         .o_protocol_err(protErr[g])
      );
   end

   // Synchronous RAM: address registered at the edge, data appears READ_LATENCY cycles later
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (ramClear) begin
            for (int a = 0; a < 4096; a++) ramMem[k][a] <= initVal(k, a);
         end else if (ramWren[k]) begin
            ramMem[k][ramAddr[k]] <= ramWrdata[k];
         end
         ramPipe[k][0] <= ramMem[k][ramAddr[k]];
         for (int s = 1; s < 8; s++) ramPipe[k][s] <= ramPipe[k][s-1];
      end
   end

   // Transaction-level reference: memory contents, when each engine is next free, sticky error
   logic [DW-1:0] shadow    [NI][4096];
   int            freeCycle [NI];
   logic          errModel  [NI];

   typedef struct {
      int            inst;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          expQ [$];
   logic [DW-1:0] lastRead [NI];
   int            checks;
   int            errors;

   task automatic checkOutput(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s inst%0d cycle %0d: got 0x%0h, expected 0x%0h", name, k, cyc, got, want);
      end
   endtask

   // Monitor: pops the scoreboard whenever a read-data pulse appears and checks data hold otherwise
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         expQ.delete();
         for (int k = 0; k < NI; k++) lastRead[k] = '0;
      end else begin
         for (int k = 0; k < NI; k++) begin
            if (rdValid[k]) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedValid", k, 32'd1, 32'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("validInst", k, k, e.inst);
                  checkOutput("rddata", k, 32'(rdData[k]), 32'(e.data));
                  checkOutput("validCycle", k, cyc, e.due);
                  lastRead[k] = e.data;
               end
            end else begin
               checkOutput("rddataHold", k, 32'(rdData[k]), 32'(lastRead[k]));
            end
         end
      end
   end

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, follow it to acceptance and record what the model expects from it
   task automatic applyStimulus(input int k, input logic isRd, input logic isWr,
                                input logic [15:0] a, input logic [DW-1:0] d);
      int tStart, expAccept, waited, acceptCyc;
      bit done, timedOut;
      tStart    = (cyc > freeCycle[k]) ? cyc : freeCycle[k];
      expAccept = tStart + wsOf(k);
      rd[k] = isRd;
      wr[k] = isWr;
      addr[k] = a;
      wrData[k] = d;
      waited = 0;
      done = 1'b0;
      timedOut = 1'b0;
      acceptCyc = 0;
      while (!done) begin
         @(negedge clk);
         if (!waitReq[k]) begin
            done = 1'b1;
            acceptCyc = cyc;
            checkOutput("acceptCycle", k, cyc, expAccept);
            checkOutput("ramWren", k, 32'(ramWren[k]), 32'(isWr));
            checkOutput("ramAddr", k, 32'(ramAddr[k]), 32'(a[AW-1:0]));
            if (isWr) checkOutput("ramWrdata", k, 32'(ramWrdata[k]), 32'(d));
         end else begin
            checkOutput("stallNoWren", k, 32'(ramWren[k]), 32'd0);
            waited++;
            if (waited > 64) begin
               checkOutput("acceptTimeout", k, 32'd1, 32'd0);
               done = 1'b1;
               timedOut = 1'b1;
            end else begin
               waitCycle();
            end
         end
      end

      if (!timedOut) begin
         if (isWr) begin
            shadow[k][a[AW-1:0]] = d;
            freeCycle[k] = acceptCyc + 1;
            if (isRd) errModel[k] = 1'b1;
         end else begin
            expQ.push_back('{inst: k, data: shadow[k][a[AW-1:0]], due: acceptCyc + latOf(k) + 1});
            freeCycle[k] = acceptCyc + latOf(k) + 1;
         end
      end

      waitCycle();
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      addr[k] = 16'($urandom);
      wrData[k] = DW'($urandom);
      @(negedge clk);
      if (!timedOut) begin
         checkOutput("ramAddrHold", k, 32'(ramAddr[k]), 32'(a[AW-1:0]));
         checkOutput("ramWrdataHold", k, 32'(ramWrdata[k]), 32'(d));
         checkOutput("ramWrenIdle", k, 32'(ramWren[k]), 32'd0);
         checkOutput("protocolErr", k, 32'(protErr[k]), 32'(errModel[k]));
      end
   endtask

   // Raise a request on an idle engine, then withdraw it while it is still being stalled
   task automatic dropStall(input int k, input int j);
      while (cyc < freeCycle[k]) waitCycle();
      wr[k] = 1'($urandom_range(0, 1));
      rd[k] = ~wr[k];
      addr[k] = 16'($urandom);
      wrData[k] = DW'($urandom);
      for (int i = 0; i <= j; i++) begin
         @(negedge clk);
         checkOutput("dropWaitreq", k, 32'(waitReq[k]), 32'd1);
         checkOutput("dropNoWren", k, 32'(ramWren[k]), 32'd0);
         waitCycle();
      end
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      @(negedge clk);
      checkOutput("dropNoWren", k, 32'(ramWren[k]), 32'd0);
      errModel[k] = 1'b1;
      waitCycle();
      @(negedge clk);
      checkOutput("protocolErr", k, 32'(protErr[k]), 32'(errModel[k]));
      freeCycle[k] = cyc;
   endtask

   // Start a read, then pull reset while it is in flight; its data pulse must never appear
   task automatic resetMidRead(input int k, input logic [15:0] a);
      applyStimulus(k, 1'b1, 1'b0, a, '0);
      #1;
      rst = 1'b1;
      rd[k] = 1'b1;
      addr[k] = a;
      @(negedge clk);
      checkOutput("rstRddata", k, 32'(rdData[k]), 32'd0);
      checkOutput("rstValid", k, 32'(rdValid[k]), 32'd0);
      checkOutput("rstErr", k, 32'(protErr[k]), 32'd0);
      checkOutput("rstWren", k, 32'(ramWren[k]), 32'd0);
      checkOutput("rstRamAddr", k, 32'(ramAddr[k]), 32'd0);
      checkOutput("rstRamWrdata", k, 32'(ramWrdata[k]), 32'd0);
      checkOutput("rstWaitreq", k, 32'(waitReq[k]), 32'(wsOf(k) != 0));
      waitCycle();
      rd[k] = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         errModel[i] = 1'b0;
         freeCycle[i] = cyc;
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r;
      rst = 1'b1;
      ramClear = 1'b1;
      checks = 0;
      errors = 0;
      for (int k = 0; k < NI; k++) begin
         rd[k] = 1'b0;
         wr[k] = 1'b0;
         addr[k] = '0;
         wrData[k] = '0;
         errModel[k] = 1'b0;
         freeCycle[k] = 0;
         for (int a = 0; a < 4096; a++) shadow[k][a] = initVal(k, a);
      end
      repeat (3) @(posedge clk);
      #1 ramClear = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         checkOutput("resetRddata", k, 32'(rdData[k]), 32'd0);
         checkOutput("resetValid", k, 32'(rdValid[k]), 32'd0);
         checkOutput("resetErr", k, 32'(protErr[k]), 32'd0);
         checkOutput("resetRamAddr", k, 32'(ramAddr[k]), 32'd0);
         checkOutput("resetWaitreq", k, 32'(waitReq[k]), 32'd0);
      end
      rst = 1'b0;
      waitCycle();
      for (int k = 0; k < NI; k++) freeCycle[k] = cyc;

      for (int k = 0; k < NI; k++) begin
         $display("[TB] instance %0d: READ_LATENCY=%0d WAIT_STATES=%0d", k, latOf(k), wsOf(k));
         applyStimulus(k, 1'b0, 1'b1, 16'h0010, 16'hBEEF); waitCycle();
         applyStimulus(k, 1'b1, 1'b0, 16'h0010, '0);       waitCycle();
         applyStimulus(k, 1'b0, 1'b1, 16'h0020, 16'h1234); waitCycle();
         applyStimulus(k, 1'b1, 1'b0, 16'h0020, '0);       waitCycle();
         applyStimulus(k, 1'b1, 1'b0, 16'hF010, '0);       waitCycle();
         applyStimulus(k, 1'b1, 1'b1, 16'h0005, 16'h00AA); waitCycle();
         applyStimulus(k, 1'b1, 1'b0, 16'h0005, '0);       waitCycle();
         resetMidRead(k, 16'h0006);
         applyStimulus(k, 1'b1, 1'b0, 16'h0006, '0);       waitCycle();
         if (wsOf(k) > 0) begin
            dropStall(k, 0);           waitCycle();
            dropStall(k, wsOf(k) - 1); waitCycle();
            applyStimulus(k, 1'b0, 1'b1, 16'h0030, 16'h5555); waitCycle();
         end

         for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
               applyStimulus(k, 1'b1, 1'b0, 16'($urandom) & 16'hF31F, '0);
            end else if (r < 90) begin
               applyStimulus(k, 1'b0, 1'b1, 16'($urandom) & 16'hF31F, DW'($urandom));
            end else if (r < 95) begin
               applyStimulus(k, 1'b1, 1'b1, 16'($urandom) & 16'hF31F, DW'($urandom));
            end else if (wsOf(k) > 0) begin
               dropStall(k, $urandom_range(0, wsOf(k) - 1));
            end else begin
               applyStimulus(k, 1'b1, 1'b0, 16'($urandom) & 16'hF31F, '0);
            end
            repeat ($urandom_range(0, 2)) waitCycle();
            waitCycle();
         end

         for (int i = 0; i < 64 && expQ.size() != 0; i++) waitCycle();
         checkOutput("drainQueue", k, expQ.size(), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_if.md
# mem_if

Memory interface stage directly downstream of the multicycle CPU control FSM and datapath. It converts the CPU's held-request handshake (`rd`/`wr` held until `wait` drops, then a one-cycle `rddatavalid` pulse) into single-cycle accesses on a synchronous on-chip RAM port. It inserts a configurable number of wait states and tracks the RAM's fixed read latency. One transaction is in flight at a time.

## Interface
- `READ_LATENCY`, default 2: RAM cycles from address to valid `i_ram_q`; legal range 1..8.
- `WAIT_STATES`, default 0: extra stall cycles before a request is accepted; legal range 0..7.
- `DATA_W`, default 16: data width.
- `RAM_AW`, default 12: RAM word-address width; only the low `RAM_AW` bits of `i_addr` are used.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_addr`  in  16  CPU word address.
- `i_rd`  in  1  read request, held until accepted.
- `i_wr`  in  1  write request, held until accepted.
- `i_wrdata`  in  DATA_W  write data.
- `o_waitrequest`  out  1  request not accepted this cycle (combinational).
- `o_rddata`  out  DATA_W  registered read data; held until the next read completes.
- `o_rddatavalid`  out  1  one-cycle pulse; `o_rddata` is valid in that cycle.
- `o_ram_addr`  out  RAM_AW  RAM address.
- `o_ram_wren`  out  1  RAM write enable.
- `o_ram_wrdata`  out  DATA_W  RAM write data.
- `i_ram_q`  in  DATA_W  RAM read data.
- `o_protocol_err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- **States:** S_IDLE, S_STALL, S_READ. Counters: `wcnt` (3 bits) and `lcnt` (`$clog2(READ_LATENCY+1)` bits).
- **Request:** `req = i_rd | i_wr`.
- **Accept condition:** `accept = req & ((S_IDLE & WAIT_STATES==0) | (S_STALL & wcnt==0))`.
- **Waitrequest:** `o_waitrequest = req & ~accept`. It is always 1 for a request arriving in S_READ.
- **RAM port:** on the accept cycle, `o_ram_addr = i_addr[RAM_AW-1:0]`, `o_ram_wrdata = i_wrdata`, `o_ram_wren = i_wr`. Otherwise `o_ram_wren = 0` and the address/data outputs hold their last accepted values (registered copy).
- **S_IDLE:**
  - On `req` with `WAIT_STATES>0`: load `wcnt = WAIT_STATES-1` and go to S_STALL.
  - On an accepted read: load `lcnt = READ_LATENCY-1` and go to S_READ.
  - On an accepted write: stay in S_IDLE.
- **S_STALL:**
  - Decrement `wcnt` each cycle. At `wcnt==0` the request is accepted: a read goes to S_READ, a write goes to S_IDLE.
  - If `req` drops during S_STALL: set `o_protocol_err` and return to S_IDLE; no RAM access occurs.
- **S_READ:**
  - Decrement `lcnt` each cycle. When `lcnt==0`, capture `i_ram_q` into `o_rddata`, set `o_rddatavalid` for the next cycle, and go to S_IDLE.
- **Simultaneous `i_rd & i_wr`:** performed as a write only (no `rddatavalid`), and `o_protocol_err` is set.
- **Address/data sampling:** values are sampled only on the accept cycle. Changes while stalled are legal and ignored.
- **Reset (any state, including mid-read):**
  - State returns to S_IDLE and counters clear.
  - The pending read is dropped; no `rddatavalid` is issued.
  - `o_rddata = 0`, `o_rddatavalid = 0`, `o_protocol_err = 0`, `o_ram_wren = 0`, `o_ram_addr = 0`, `o_ram_wrdata = 0`.
  - `o_waitrequest` follows its equation, with state forced to S_IDLE.

## Timing
- **Accept cycle:** `A = T + WAIT_STATES`, where T is the first cycle `req` is high in S_IDLE.
- **Read:** RAM address is presented in cycle A. `i_ram_q` is sampled at the end of cycle `A+READ_LATENCY`. `o_rddatavalid` is high in cycle `A+READ_LATENCY+1` only.
- **Write:** RAM write occurs in cycle A. The block is free again at A+1.
- **Back-to-back:** in the cycle `o_rddatavalid` is high, state is S_IDLE and a new request may be accepted.
- **Lockout:** no request is accepted during S_READ.

## Test plan
- **Read, L=2, W=0:** RAM[0x010]=0xBEEF; `i_rd=1` at cycle 0 with addr 0x0010.
  - Response: `waitrequest=0` at cycle 0, `ram_addr=0x010`; `rddatavalid=1` with `rddata=0xBEEF` at cycle 3 only.
- **Write, W=2:** `i_wr=1`, addr 0x0020, data 0x1234 from cycle 0.
  - Response: `waitrequest=1` in cycles 0–1, 0 in cycle 2; `ram_wren=1` in cycle 2 only; a later read of 0x20 returns 0x1234.
- **Back-to-back, L=1, W=1:** read 0x5 (RAM=0x00AA), then a read request to 0x6 (RAM=0x00BB) in the valid cycle.
  - Response: first `rddatavalid` at cycle 3 with data 0x00AA; second read accepted at cycle 4, valid at cycle 6 with data 0x00BB.
- **Reset mid-read, L=4:** assert `rst` at cycle 2 after a read is accepted at cycle 0.
  - Response: `rddatavalid` never pulses, `rddata=0`, state S_IDLE; a following read completes normally.
- **Protocol errors:**
  - `i_rd=i_wr=1`: response is a write performed, no valid pulse, `o_protocol_err=1`.
  - Request dropped during S_STALL (W=3): response is `o_protocol_err=1` and no RAM access.
  - In both cases the flag stays at 1 until `rst`.
